// File: rtl/ch0_copy_eng.sv
// ---------------------------------------------------------------------------
// ch0_copy_eng
// Channel-0 data mover. Pops 64-bit words from the source FIFO, optionally
// byte-reverses them, stages them in a 2-entry skid buffer and pushes them to
// the destination FIFO. Moves a programmed word count, stops early on
// m_last, then pulses done.
//
// Optional feature macro: CH0_CSUM_EN adds a running 32-bit checksum (csum)
// of every pushed word (upper half + lower half, mod 2^32).
//
// Ports
//   wb_clk_i, wb_rst_ni        clock, async active-low reset
//   start, dc, swap            transfer request (sampled while idle)
//   busy, done, short_o        transfer status
//   xfer_cnt                   words pushed in current/last transfer
//   m_src_getn, m_src,
//   m_last, m_src_empty        source FIFO side (data valid the cycle after a pop)
//   m_dst_putn, m_dst,
//   m_dst_full                 destination FIFO side
//   csum                       checksum (CH0_CSUM_EN only)
// ---------------------------------------------------------------------------
module ch0_copy_eng #(
   parameter int unsigned CNT_W  = 24,
   parameter int unsigned SKID_D = 2
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_ni,
   input  logic             start,
   input  logic [CNT_W-1:0] dc,
   input  logic             swap,
   output logic             busy,
   output logic             done,
   output logic             short_o,
   output logic [CNT_W-1:0] xfer_cnt,
   output logic             m_src_getn,
   input  logic [63:0]      m_src,
   input  logic             m_last,
   input  logic             m_src_empty,
   output logic             m_dst_putn,
   output logic [63:0]      m_dst,
   input  logic             m_dst_full
`ifdef CH0_CSUM_EN
   ,
   output logic [31:0]      csum
`endif
);

   localparam int unsigned DW     = 64;
   localparam int unsigned BW     = 8;
   localparam int unsigned NB     = DW / BW;
   localparam int unsigned PTR_W  = 1;
   localparam int unsigned OCC_W  = 2;
   localparam int unsigned LVL_W  = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   rem_q, rem_d;
   logic               swap_q, swap_d;
   logic               short_q, short_d;
   logic [CNT_W-1:0]   xfer_cnt_q, xfer_cnt_d;
   logic               inflight_q, inflight_d;
   logic [OCC_W-1:0]   occ_q, occ_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [DW-1:0]      mem_q [SKID_D];
   logic [DW-1:0]      mem_d [SKID_D];
`ifdef CH0_CSUM_EN
   logic [31:0]        csum_q, csum_d;
`endif

   logic               push_c;
   logic               pop_c;
   logic               last_now_c;
   logic [LVL_W-1:0]   level_c;
   logic [DW-1:0]      swapped_c;
   logic [DW-1:0]      din_c;

   // Byte reversal of the arriving word: byte i -> byte 7-i
   always_comb begin
      swapped_c = '0;
      for (int unsigned i = 0; i < NB; i++) begin
         swapped_c[i*BW +: BW] = m_src[(NB-1-i)*BW +: BW];
      end
      din_c = swap_q ? swapped_c : m_src;
   end

   // Pop/push handshakes. A word carrying m_last blocks a pop in its own
   // arrival cycle, so nothing is popped past the last word. A push in the
   // current cycle frees a slot, which keeps 1 word/clk without overflow.
   always_comb begin
      push_c     = (occ_q != '0) && !m_dst_full;
      last_now_c = inflight_q && m_last;
      level_c    = LVL_W'(occ_q) + LVL_W'(inflight_q) - LVL_W'(push_c);
      pop_c      = (state_q == RUN) && !m_src_empty && (rem_q != '0) &&
                   !last_now_c && (level_c < LVL_W'(SKID_D));
   end

   // Next-state and datapath
   always_comb begin
      state_d    = state_q;
      rem_d      = rem_q;
      swap_d     = swap_q;
      short_d    = short_q;
      xfer_cnt_d = xfer_cnt_q;
      inflight_d = pop_c;
      occ_d      = occ_q + OCC_W'(inflight_q) - OCC_W'(push_c);
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      mem_d      = mem_q;
`ifdef CH0_CSUM_EN
      csum_d     = csum_q;
`endif

      if (push_c) begin
         xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
         rd_ptr_d   = rd_ptr_q + PTR_W'(1);
`ifdef CH0_CSUM_EN
         csum_d     = csum_q + m_dst[63:32] + m_dst[31:0];
`endif
      end

      if (inflight_q) begin
         mem_d[wr_ptr_q] = din_c;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end

      if (pop_c) begin
         rem_d = rem_q - CNT_W'(1);
      end

      unique case (state_q)
         IDLE: begin
            if (start) begin
               swap_d     = swap;
               short_d    = 1'b0;
               xfer_cnt_d = '0;
`ifdef CH0_CSUM_EN
               csum_d     = '0;
`endif
               if (dc == '0) begin
                  state_d = DONE;
               end else begin
                  rem_d   = dc;
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            // rem_q already reflects this word's own decrement here
            if (last_now_c) begin
               short_d = (rem_q != '0);
               state_d = DRAIN;
            end else if (rem_d == '0) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if ((occ_d == '0) && !inflight_d) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q    <= IDLE;
         rem_q      <= '0;
         swap_q     <= 1'b0;
         short_q    <= 1'b0;
         xfer_cnt_q <= '0;
         inflight_q <= 1'b0;
         occ_q      <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         for (int unsigned i = 0; i < SKID_D; i++) begin
            mem_q[i] <= '0;
         end
`ifdef CH0_CSUM_EN
         csum_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         rem_q      <= rem_d;
         swap_q     <= swap_d;
         short_q    <= short_d;
         xfer_cnt_q <= xfer_cnt_d;
         inflight_q <= inflight_d;
         occ_q      <= occ_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         mem_q      <= mem_d;
`ifdef CH0_CSUM_EN
         csum_q     <= csum_d;
`endif
      end
   end

   // Skid buffer must never overflow or underflow
   always @(posedge wb_clk_i) begin : skid_chk
      if (wb_rst_ni) begin
         assert (!(inflight_q && !push_c && (occ_q == OCC_W'(SKID_D))));
         assert (!(!m_dst_putn && (occ_q == '0)));
      end
   end

   assign busy       = (state_q == RUN) || (state_q == DRAIN);
   assign done       = (state_q == DONE);
   assign short_o    = short_q;
   assign xfer_cnt   = xfer_cnt_q;
   assign m_src_getn = ~pop_c;
   assign m_dst_putn = ~push_c;
   assign m_dst      = mem_q[rd_ptr_q];
`ifdef CH0_CSUM_EN
   assign csum       = csum_q;
`endif

endmodule

// File: tb/tb_ch0_copy_eng.sv
// ---------------------------------------------------------------------------
// tb_ch0_copy_eng
// Directed bench for ch0_copy_eng: behavioural source/destination FIFOs,
// linear directed steps, immediate-assertion checks, one summary line.
// ---------------------------------------------------------------------------
module tb_ch0_copy_eng;

   localparam int unsigned CNT_W = 24;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic [CNT_W-1:0] dc;
   logic             swap;
   logic             busy;
   logic             done;
   logic             short_o;
   logic [CNT_W-1:0] xfer_cnt;
   logic             m_src_getn;
   logic [63:0]      m_src = '0;
   logic             m_last = 1'b0;
   logic             m_src_empty;
   logic             m_dst_putn;
   logic [63:0]      m_dst;
   logic             m_dst_full;
`ifdef CH0_CSUM_EN
   logic [31:0]      csum;
`endif

   int n_cmp = 0;
   int n_err = 0;

   ch0_copy_eng #(.CNT_W(CNT_W), .SKID_D(2)) dut (
      .wb_clk_i    (clk),
      .wb_rst_ni   (rst_n),
      .start       (start),
      .dc          (dc),
      .swap        (swap),
      .busy        (busy),
      .done        (done),
      .short_o     (short_o),
      .xfer_cnt    (xfer_cnt),
      .m_src_getn  (m_src_getn),
      .m_src       (m_src),
      .m_last      (m_last),
      .m_src_empty (m_src_empty),
      .m_dst_putn  (m_dst_putn),
      .m_dst       (m_dst),
      .m_dst_full  (m_dst_full)
`ifdef CH0_CSUM_EN
      ,
      .csum        (csum)
`endif
   );

   always #5 clk = ~clk;

   // Source FIFO model: data appears the cycle after a pop
   logic [63:0] src_mem  [64];
   logic        src_last [64];
   int          src_n = 0;
   int          src_idx = 0;
   logic        flush;
   int          cyc = 0;
   int          pop_n = 0;
   int          pop_cyc [64];
   int          pop_empty_n = 0;

   assign m_src_empty = (src_idx >= src_n);

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (flush) begin
         src_idx <= src_n;
      end else if (!m_src_getn) begin
         if (src_idx >= src_n) pop_empty_n <= pop_empty_n + 1;
         m_src            <= src_mem[src_idx[5:0]];
         m_last           <= src_last[src_idx[5:0]];
         src_idx          <= src_idx + 1;
         pop_cyc[pop_n[5:0]] <= cyc;
         pop_n            <= pop_n + 1;
      end
   end

   // Destination FIFO model: records every pushed word and its cycle
   logic [63:0] dst_mem [64];
   int          dst_cyc [64];
   int          dst_n = 0;

   always @(posedge clk) begin
      if (!m_dst_putn) begin
         dst_mem[dst_n[5:0]] <= m_dst;
         dst_cyc[dst_n[5:0]] <= cyc;
         dst_n               <= dst_n + 1;
      end
   end

   // Words popped but not yet pushed; discarded by reset
   int pend = 0;
   int max_pend = 0;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) pend <= 0;
      else        pend <= pend + (m_src_getn ? 0 : 1) - (m_dst_putn ? 0 : 1);
   end
   always @(posedge clk) begin
      if (pend > max_pend) max_pend <= pend;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic go(input logic [CNT_W-1:0] cnt, input logic sw);
      @(negedge clk);
      start = 1'b1;
      dc    = cnt;
      swap  = sw;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int bound, input string tag);
      int k;
      k = 0;
      while (done !== 1'b1 && k < bound) begin
         @(negedge clk);
         k++;
      end
      chk(tag, 64'(done), 64'd1);
   endtask

   task automatic load(input logic [63:0] base, input int n, input int last_at);
      for (int k = 0; k < n; k++) begin
         src_mem[(src_n + k) % 64]  = base + 64'(k);
         src_last[(src_n + k) % 64] = (k == last_at);
      end
      src_n = src_n + n;
   endtask

   task automatic do_flush();
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin : stim
      int p0;
      int d0;
      int done_cyc;
      int k;

      rst_n      = 1'b0;
      start      = 1'b0;
      dc         = '0;
      swap       = 1'b0;
      m_dst_full = 1'b0;
      flush      = 1'b0;

      // Reset values
      #1;
      chk("rst_busy",  64'(busy),       64'd0);
      chk("rst_done",  64'(done),       64'd0);
      chk("rst_short", 64'(short_o),    64'd0);
      chk("rst_xfer",  64'(xfer_cnt),   64'd0);
      chk("rst_getn",  64'(m_src_getn), 64'd1);
      chk("rst_putn",  64'(m_dst_putn), 64'd1);
      chk("rst_mdst",  m_dst,           64'd0);
`ifdef CH0_CSUM_EN
      chk("rst_csum",  64'(csum),       64'd0);
`endif
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // 1: dc=4, four words, destination never full
      load(64'hA0A0_0000_0F0F_0000, 4, -1);
      p0 = pop_n;
      d0 = dst_n;
      go(24'd4, 1'b0);
      wait_done(50, "t1_done");
      done_cyc = cyc;
      chk("t1_npush", 64'(dst_n - d0), 64'd4);
      chk("t1_npop",  64'(pop_n - p0), 64'd4);
      for (int i = 0; i < 4; i++)
         chk("t1_data", dst_mem[d0 + i], 64'hA0A0_0000_0F0F_0000 + 64'(i));
      chk("t1_xfer",  64'(xfer_cnt), 64'd4);
      chk("t1_short", 64'(short_o),  64'd0);
      chk("t1_busy",  64'(busy),     64'd0);
      chk("t1_lat",   64'(dst_cyc[d0] - pop_cyc[p0]), 64'd2);
      chk("t1_rate",  64'(dst_cyc[d0 + 3] - dst_cyc[d0]), 64'd3);
      chk("t1_donecyc", 64'(done_cyc - dst_cyc[d0 + 3]), 64'd1);
      @(negedge clk);
      chk("t1_done_pulse", 64'(done), 64'd0);

      // 2: dc=0 -> done the cycle after start, no pops
      p0 = pop_n;
      go(24'd0, 1'b0);
      chk("t2_done", 64'(done),       64'd1);
      chk("t2_getn", 64'(m_src_getn), 64'd1);
      chk("t2_xfer", 64'(xfer_cnt),   64'd0);
      @(negedge clk);
      chk("t2_done_off", 64'(done), 64'd0);
      chk("t2_npop", 64'(pop_n - p0), 64'd0);

      // 3: dc=8 with destination full for 5 clocks mid-burst
      load(64'hC3C3_0000_0000_0000, 8, -1);
      d0 = dst_n;
      go(24'd8, 1'b0);
      repeat (3) @(negedge clk);
      m_dst_full = 1'b1;
      repeat (5) @(negedge clk);
      m_dst_full = 1'b0;
      wait_done(100, "t3_done");
      chk("t3_npush", 64'(dst_n - d0), 64'd8);
      for (int i = 0; i < 8; i++)
         chk("t3_data", dst_mem[d0 + i], 64'hC3C3_0000_0000_0000 + 64'(i));
      chk("t3_xfer",   64'(xfer_cnt), 64'd8);
      chk("t3_maxout", 64'(max_pend <= 2), 64'd1);
      chk("t3_popempty", 64'(pop_empty_n), 64'd0);

      // 4: dc=10, m_last on the third word -> early stop
      load(64'hD4D4_0000_0000_0000, 5, 2);
      p0 = pop_n;
      d0 = dst_n;
      go(24'd10, 1'b0);
      wait_done(100, "t4_done");
      chk("t4_npush", 64'(dst_n - d0), 64'd3);
      for (int i = 0; i < 3; i++)
         chk("t4_data", dst_mem[d0 + i], 64'hD4D4_0000_0000_0000 + 64'(i));
      chk("t4_short", 64'(short_o),    64'd1);
      chk("t4_xfer",  64'(xfer_cnt),   64'd3);
      chk("t4_npop",  64'(pop_n - p0), 64'd3);
      do_flush();

      // 5: swap, single word that also carries m_last with rem reaching 0
      load(64'h0011_2233_4455_6677, 1, 0);
      d0 = dst_n;
      go(24'd1, 1'b1);
      wait_done(50, "t5_done");
      chk("t5_npush", 64'(dst_n - d0), 64'd1);
      chk("t5_data",  dst_mem[d0],     64'h7766_5544_3322_1100);
      chk("t5_short", 64'(short_o),    64'd0);
      chk("t5_xfer",  64'(xfer_cnt),   64'd1);
`ifdef CH0_CSUM_EN
      chk("t5_csum",  64'(csum),       64'h0000_0000_AA88_6644);
`endif

      // 6: reset mid-transfer after two pushes, then a clean dc=3 transfer
      load(64'hE6E6_0000_0000_0000, 6, -1);
      d0 = dst_n;
      go(24'd6, 1'b0);
      k = 0;
      while ((dst_n - d0) < 2 && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("t6_two_pushes", 64'(dst_n - d0 >= 2), 64'd1);
      chk("t6_busy_pre",   64'(busy),            64'd1);
      rst_n = 1'b0;
      #1;
      chk("t6_busy",  64'(busy),       64'd0);
      chk("t6_done",  64'(done),       64'd0);
      chk("t6_short", 64'(short_o),    64'd0);
      chk("t6_xfer",  64'(xfer_cnt),   64'd0);
      chk("t6_getn",  64'(m_src_getn), 64'd1);
      chk("t6_putn",  64'(m_dst_putn), 64'd1);
      chk("t6_mdst",  m_dst,           64'd0);
`ifdef CH0_CSUM_EN
      chk("t6_csum",  64'(csum),       64'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      do_flush();
      load(64'hF7F7_0000_0000_0000, 3, -1);
      d0 = dst_n;
      go(24'd3, 1'b0);
      wait_done(50, "t6b_done");
      chk("t6b_npush", 64'(dst_n - d0), 64'd3);
      for (int i = 0; i < 3; i++)
         chk("t6b_data", dst_mem[d0 + i], 64'hF7F7_0000_0000_0000 + 64'(i));
      chk("t6b_xfer",  64'(xfer_cnt),  64'd3);
      chk("t6b_short", 64'(short_o),   64'd0);
      chk("end_maxout", 64'(max_pend <= 2), 64'd1);
      chk("end_popempty", 64'(pop_empty_n), 64'd0);

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
